stdp_weight_ctrl: RTL and testbench

- Requester and consumer side of the STDP delta-weight lookup.
- Tracks time since the last pre- and post-synaptic spike for one synapse.
- On a qualifying spike pairing, drives the spike-time difference as the lookup index and waits for the registered 24-bit delta.
- Adds the delta to the synapse weight register with saturation; the weight feeds the neuron accumulation path.

---
 rtl/stdp_weight_ctrl_pkg.sv | 13 +
 rtl/stdp_weight_ctrl_if.sv | 14 +
 rtl/stdp_weight_ctrl_timer.sv | 13 +
 rtl/stdp_weight_ctrl.sv | 59 +++++
 tb/tb_stdp_weight_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/stdp_weight_ctrl_pkg.sv
// stdp_pkg: FSM state encoding, dt window defaults, timer saturation value and signed saturating add
package stdp_pkg;
  typedef enum logic [1:0] {IDLE, REQ, CAPT, APPLY} state_t;
  localparam int DT_MIN_DEF = 2;
  localparam int DT_MAX_DEF = 20;
  localparam int TW_DEF = 8;
  localparam logic [TW_DEF-1:0] TIMER_SAT = '1;
  function automatic longint sat_add(input longint a, input longint b, input longint lo, input longint hi);
    longint s;
    s = a + b;
    return s > hi ? hi : (s < lo ? lo : s);
  endfunction
endpackage

// File: rtl/stdp_weight_ctrl_if.sv
// stdp_weight_ctrl_if: spike/tick inputs, delta lookup request/response and weight-side outputs
interface stdp_weight_ctrl_if #(parameter int TW = 8, parameter int WW = 24);
  logic tick;
  logic pre_spike;
  logic post_spike;
  logic [TW-1:0] lut_idx;
  logic [WW-1:0] lut_val;
  logic [WW-1:0] weight;
  logic upd_done;
  logic busy;
  logic drop;
  modport master (input tick, pre_spike, post_spike, lut_val, output lut_idx, weight, upd_done, busy, drop);
  modport slave (output tick, pre_spike, post_spike, lut_val, input lut_idx, weight, upd_done, busy, drop);
endinterface

// File: rtl/stdp_weight_ctrl_timer.sv
// spike_timer: time since last spike, cleared by load, advanced by tick, saturating at all-ones
module spike_timer #(parameter int TW = 8) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          load,
  output logic [TW-1:0] t
);
  always_ff @(posedge clk)
    if (!rst) t <= '1;
    else if (load) t <= '0;
    else if (tick && t != '1) t <= t + TW'(1);
endmodule

// File: rtl/stdp_weight_ctrl.sv
// stdp_weight_ctrl: STDP pairing detector, delta lookup requester and saturating weight update; STDP_BIDIR_EN adds pre-triggered depression
module stdp_weight_ctrl import stdp_pkg::*; #(
  parameter int TW = TW_DEF,
  parameter int WW = 24,
  parameter int DT_MIN = DT_MIN_DEF,
  parameter int DT_MAX = DT_MAX_DEF,
  parameter logic [WW-1:0] W_INIT = '0,
  parameter logic [WW-1:0] W_MAX = 24'h7FFFFF,
  parameter logic [WW-1:0] W_MIN = 24'h800000
) (
  input logic clk,
  input logic rst,
  stdp_weight_ctrl_if.master bus
);
  localparam logic [TW-1:0] LO = TW'(DT_MIN);
  localparam logic [TW-1:0] HI = TW'(DT_MAX);
  localparam longint WMAX_L = longint'($signed(W_MAX));
  localparam longint WMIN_L = longint'($signed(W_MIN));
  state_t state, nxt;
  logic [TW-1:0] pre_t, post_t;
  logic [WW-1:0] delta_r;
  logic signed [WW:0] delta_x;
  logic q_post, q_pre, neg;
  spike_timer #(.TW(TW)) u_pre (.clk(clk), .rst(rst), .tick(bus.tick), .load(bus.pre_spike), .t(pre_t));
  spike_timer #(.TW(TW)) u_post (.clk(clk), .rst(rst), .tick(bus.tick), .load(bus.post_spike), .t(post_t));
  // dt is the timer value before this cycle's spike clears it
  assign q_post = bus.post_spike && pre_t >= LO && pre_t <= HI;
`ifdef STDP_BIDIR_EN
  assign q_pre = bus.pre_spike && post_t >= LO && post_t <= HI;
`else
  logic unused_post;
  assign q_pre = 1'b0;
  assign unused_post = ^post_t;
`endif
  assign delta_x = neg ? -{delta_r[WW-1], delta_r} : {delta_r[WW-1], delta_r};
  always_ff @(posedge clk) state <= !rst ? IDLE : nxt;
  always_comb nxt = state == IDLE ? ((q_post || q_pre) ? REQ : IDLE) :
                    state == REQ  ? CAPT :
                    state == CAPT ? APPLY : IDLE;
  always_comb begin
    bus.busy = rst && state != IDLE;
    bus.upd_done = rst && state == APPLY;
    bus.drop = rst && (state != IDLE ? (q_post || q_pre) : (q_post && q_pre));
  end
  always_ff @(posedge clk)
    if (!rst) begin
      bus.lut_idx <= '0;
      bus.weight <= W_INIT;
      delta_r <= '0;
      neg <= 1'b0;
    end else begin
      if (state == IDLE && (q_post || q_pre)) begin
        bus.lut_idx <= q_post ? pre_t : post_t;
        neg <= !q_post;
      end
      if (state == CAPT) delta_r <= bus.lut_val;
      if (state == APPLY) bus.weight <= WW'(sat_add(longint'($signed(bus.weight)), longint'(delta_x), WMIN_L, WMAX_L));
    end
endmodule

// File: tb/tb_stdp_weight_ctrl.sv
// tb_stdp_weight_ctrl: directed and random spike trains checked against a cycle-level STDP reference model
module tb_stdp_weight_ctrl;
  import stdp_pkg::*;
  localparam longint WLO = -8388608;
  localparam longint WHI = 8388607;
  localparam longint W2_INIT = -8388603;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  stdp_weight_ctrl_if b1 ();
  stdp_weight_ctrl_if b2 ();
  stdp_weight_ctrl dut (.clk(clk), .rst(rst), .bus(b1));
  stdp_weight_ctrl #(.W_INIT(24'h800005)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  longint tbl [256];
  always @(posedge clk) begin
    b1.lut_val <= 24'(tbl[b1.lut_idx]);
    b2.lut_val <= 24'(tbl[b2.lut_idx]);
  end
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pre_m, post_m, age, idx_m, last_idx;
  bit neg_m;
  longint w1, w2, wb;
  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, act, exp);
    end
  endtask
  function automatic longint clamp(input longint s);
    return s > WHI ? WHI : (s < WLO ? WLO : s);
  endfunction
  function automatic bit in_win(input int t);
    return t >= 2 && t <= 20;
  endfunction
  function automatic int timer_next(input int t, input bit spk, input bit tk);
    return spk ? 0 : (tk && t < 255) ? t + 1 : t;
  endfunction
  task automatic model_reset();
    pre_m = 255;
    post_m = 255;
    age = 0;
    last_idx = 0;
    w1 = 0;
    w2 = W2_INIT;
  endtask
  task automatic drive(input bit pr, input bit po, input bit tk);
    b1.pre_spike = pr;
    b2.pre_spike = pr;
    b1.post_spike = po;
    b2.post_spike = po;
    b1.tick = tk;
    b2.tick = tk;
  endtask
  task automatic step(input bit pr, input bit po, input bit tk);
    bit qp, qq, bsy, acc;
    int n;
    longint d;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(pr, po, tk);
    @(negedge clk);
    cyc++;
    qp = po && in_win(pre_m);
`ifdef STDP_BIDIR_EN
    qq = pr && in_win(post_m);
`else
    qq = 1'b0;
`endif
    n = int'(qp) + int'(qq);
    bsy = age != 0;
    acc = !bsy && n > 0;
    check("busy", b1.busy, bsy);
    check("upd_done", b1.upd_done, age == 3);
    check("upd_done2", b2.upd_done, age == 3);
    check("drop", b1.drop, (n - int'(acc)) > 0);
    check("lut_idx", b1.lut_idx, last_idx);
    check("weight", $signed(b1.weight), w1);
    check("weight2", $signed(b2.weight), w2);
    if (age == 3) begin
      d = neg_m ? -tbl[idx_m] : tbl[idx_m];
      w1 = clamp(w1 + d);
      w2 = clamp(w2 + d);
      age = 0;
    end else if (age != 0) age++;
    else if (acc) begin
      age = 1;
      idx_m = qp ? pre_m : post_m;
      neg_m = !qp;
      last_idx = idx_m;
    end
    pre_m = timer_next(pre_m, pr, tk);
    post_m = timer_next(post_m, po, tk);
  endtask
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(0, 0, 0);
      @(negedge clk);
      cyc++;
      check("rst_upd_done", b1.upd_done, 0);
      check("rst_busy", b1.busy, 0);
      check("rst_drop", b1.drop, 0);
    end
    if (n > 1) begin
      check("rst_pre_t", dut.pre_t, TIMER_SAT);
      check("rst_post_t", dut.post_t, TIMER_SAT);
      check("rst_weight", $signed(b1.weight), 0);
      check("rst_weight2", $signed(b2.weight), W2_INIT);
      check("rst_lut_idx", b1.lut_idx, 0);
    end
    model_reset();
  endtask
  task automatic pair(input int dt);
    step(1, 0, 0);
    repeat (dt) step(0, 0, 1);
    step(0, 1, 0);
    repeat (4) step(0, 0, 0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = longint'($urandom_range(0, 2000)) - 1000;
    tbl[2] = -19;
    tbl[3] = -19;
    tbl[20] = -181;
    tbl[10] = -7340032;
    tbl[11] = 7340032;
    tbl[12] = WLO;
    drive(0, 0, 0);
    do_reset(3);
    pair(2);
    check("basic_dt2", $signed(b1.weight), -19);
    check("sat_low", $signed(b2.weight), WLO);
    wb = w1;
    pair(1);
    pair(21);
    check("window_edges", $signed(b1.weight), wb);
    wb = w1;
    pair(20);
    check("dt20", $signed(b1.weight), wb - 181);
    wb = w1;
    step(1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    repeat (4) step(0, 0, 0);
    check("busy_one_update", $signed(b1.weight), wb - 19);
    step(1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 0, 0);
    do_reset(1);
    step(0, 0, 0);
    check("midop_rst_weight", $signed(b1.weight), 0);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset(1);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
